// File: rtl/ili934x_pkg.sv
// Shared constants and request payload for the ILI934x fill path.
package ili934x_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam int unsigned HDR_LEN   = 11;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned PIX_CNT_W = 17;

  // Latched fill-rectangle request.
  typedef struct packed {
    logic [15:0] x0;
    logic [15:0] x1;
    logic [15:0] y0;
    logic [15:0] y1;
    logic [15:0] color;
  } fill_req_t;

endpackage

// File: rtl/lcd_fill_sequencer.sv
// Expands one fill-rectangle request into the CASET/PASET/RAMWR header plus
// RGB565 pixel bytes for the 8080 byte writer's item stream.
module lcd_fill_sequencer
  import ili934x_pkg::*;
#(
  parameter int unsigned H_RES = 240,
  parameter int unsigned V_RES = 320
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_x0,
  input  logic [15:0] req_x1,
  input  logic [15:0] req_y0,
  input  logic [15:0] req_y1,
  input  logic [15:0] req_color,
  output logic        item_valid,
  output logic        item_is_cmd,
  output logic [7:0]  item_byte,
  input  logic        item_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    HDR,
    PIX,
    DONE
  } fill_state_e;

  localparam logic [IDX_W-1:0] HDR_LAST = IDX_W'(HDR_LEN - 1);

  fill_state_e            state_q, state_d;
  fill_req_t              req_q, req_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [PIX_CNT_W-1:0]   pix_left_q, pix_left_d;
  logic                   lo_phase_q, lo_phase_d;
  logic                   item_valid_q, item_valid_d;
  logic                   item_cmd_q, item_cmd_d;
  logic [7:0]             item_byte_q, item_byte_d;
  logic                   req_ready_q;
  logic                   busy_q;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   xfer_c;
  logic                   req_ok_c;
  logic [PIX_CNT_W-1:0]   width_c;
  logic [PIX_CNT_W-1:0]   height_c;
  logic [PIX_CNT_W-1:0]   area_c;

  // Header item at a given index: {is_cmd, byte}.
  function automatic logic [8:0] hdr_item(input logic [IDX_W-1:0] idx,
                                          input fill_req_t       r);
    logic [8:0] item;
    case (idx)
      4'd0:    item = {1'b1, CMD_CASET};
      4'd1:    item = {1'b0, r.x0[15:8]};
      4'd2:    item = {1'b0, r.x0[7:0]};
      4'd3:    item = {1'b0, r.x1[15:8]};
      4'd4:    item = {1'b0, r.x1[7:0]};
      4'd5:    item = {1'b1, CMD_PASET};
      4'd6:    item = {1'b0, r.y0[15:8]};
      4'd7:    item = {1'b0, r.y0[7:0]};
      4'd8:    item = {1'b0, r.y1[15:8]};
      4'd9:    item = {1'b0, r.y1[7:0]};
      4'd10:   item = {1'b1, CMD_RAMWR};
      default: item = 9'h000;
    endcase
    return item;
  endfunction

  // Window validation and pixel count from the latched request.
  assign xfer_c   = item_valid_q && item_ready;
  assign req_ok_c = (req_q.x0 <= req_q.x1) && (req_q.y0 <= req_q.y1) &&
                    (32'(req_q.x1) < H_RES) && (32'(req_q.y1) < V_RES);
  assign width_c  = PIX_CNT_W'(req_q.x1) - PIX_CNT_W'(req_q.x0) + PIX_CNT_W'(1);
  assign height_c = PIX_CNT_W'(req_q.y1) - PIX_CNT_W'(req_q.y0) + PIX_CNT_W'(1);
  assign area_c   = PIX_CNT_W'(width_c * height_c);

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    idx_d        = idx_q;
    pix_left_d   = pix_left_q;
    lo_phase_d   = lo_phase_q;
    item_valid_d = item_valid_q;
    item_cmd_d   = item_cmd_q;
    item_byte_d  = item_byte_q;
    done_d       = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d.x0    = req_x0;
          req_d.x1    = req_x1;
          req_d.y0    = req_y0;
          req_d.y1    = req_y1;
          req_d.color = req_color;
          state_d     = CALC;
        end
      end

      CALC: begin
        if (!req_ok_c) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          pix_left_d                = area_c;
          idx_d                     = '0;
          lo_phase_d                = 1'b0;
          item_valid_d              = 1'b1;
          {item_cmd_d, item_byte_d} = hdr_item('0, req_q);
          state_d                   = HDR;
        end
      end

      HDR: begin
        if (xfer_c) begin
          if (idx_q == HDR_LAST) begin
            lo_phase_d  = 1'b0;
            item_cmd_d  = 1'b0;
            item_byte_d = req_q.color[15:8];
            state_d     = PIX;
          end else begin
            idx_d                     = idx_q + IDX_W'(1);
            {item_cmd_d, item_byte_d} = hdr_item(idx_q + IDX_W'(1), req_q);
          end
        end
      end

      PIX: begin
        if (xfer_c) begin
          if (!lo_phase_q) begin
            lo_phase_d  = 1'b1;
            item_byte_d = req_q.color[7:0];
          end else begin
            pix_left_d = pix_left_q - PIX_CNT_W'(1);
            if (pix_left_q == PIX_CNT_W'(1)) begin
              item_valid_d = 1'b0;
              done_d       = 1'b1;
              state_d      = DONE;
            end else begin
              lo_phase_d  = 1'b0;
              item_byte_d = req_q.color[15:8];
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      idx_q        <= '0;
      pix_left_q   <= '0;
      lo_phase_q   <= 1'b0;
      item_valid_q <= 1'b0;
      item_cmd_q   <= 1'b0;
      item_byte_q  <= 8'h00;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      idx_q        <= idx_d;
      pix_left_q   <= pix_left_d;
      lo_phase_q   <= lo_phase_d;
      item_valid_q <= item_valid_d;
      item_cmd_q   <= item_cmd_d;
      item_byte_q  <= item_byte_d;
      req_ready_q  <= (state_d == IDLE);
      busy_q       <= (state_d != IDLE);
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign item_valid  = item_valid_q;
  assign item_is_cmd = item_cmd_q;
  assign item_byte   = item_byte_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_lcd_fill_sequencer.sv
// Bench for lcd_fill_sequencer: directed and random fill requests checked
// against a queue-based stream model.
module tb_lcd_fill_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_x0, req_x1, req_y0, req_y1, req_color;
  logic        item_valid;
  logic        item_is_cmd;
  logic [7:0]  item_byte;
  logic        item_ready;
  logic        busy, done, err;

  int n_assert = 0;
  int n_fail   = 0;

  int cyc = 0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  int acc_cnt, acc_cyc, done_cnt, done_cyc, err_cnt, err_cyc;
  int first_valid_cyc, valid_cnt, last_xfer_cyc, busy_low_cnt;
  int ready_pct = 100;
  logic track_busy = 1'b0;
  logic prev_stall = 1'b0;
  logic [8:0] prev_item = '0;

  lcd_fill_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x0     (req_x0),
    .req_x1     (req_x1),
    .req_y0     (req_y0),
    .req_y1     (req_y1),
    .req_color  (req_color),
    .item_valid (item_valid),
    .item_is_cmd(item_is_cmd),
    .item_byte  (item_byte),
    .item_ready (item_ready),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: observe at the falling edge, then drive after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (prev_stall)
      check("hold", 32'({item_valid, item_is_cmd, item_byte}), 32'({1'b1, prev_item}));
    prev_stall = rst_n && item_valid && !item_ready;
    prev_item  = {item_is_cmd, item_byte};
    if (rst_n && item_valid && item_ready) begin
      got_q.push_back({item_is_cmd, item_byte});
      last_xfer_cyc = cyc;
    end
    if (item_valid) begin
      valid_cnt++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err)  begin err_cnt++;  err_cyc  = cyc; end
    if (rst_n && req_valid && req_ready) begin acc_cnt++; acc_cyc = cyc; end
    if (track_busy && !busy && !err) busy_low_cnt++;
    cyc++;
    @(posedge clk);
    #1;
    item_ready = ($urandom_range(0, 99) < ready_pct);
  endtask

  // Expected stream of one request, appended to exp_q.
  task automatic build_exp(input logic [15:0] x0, x1, y0, y1, col);
    int n;
    n = (int'(x1) - int'(x0) + 1) * (int'(y1) - int'(y0) + 1);
    exp_q.push_back({1'b1, 8'h2A});
    exp_q.push_back({1'b0, x0[15:8]});
    exp_q.push_back({1'b0, x0[7:0]});
    exp_q.push_back({1'b0, x1[15:8]});
    exp_q.push_back({1'b0, x1[7:0]});
    exp_q.push_back({1'b1, 8'h2B});
    exp_q.push_back({1'b0, y0[15:8]});
    exp_q.push_back({1'b0, y0[7:0]});
    exp_q.push_back({1'b0, y1[15:8]});
    exp_q.push_back({1'b0, y1[7:0]});
    exp_q.push_back({1'b1, 8'h2C});
    repeat (n) begin
      exp_q.push_back({1'b0, col[15:8]});
      exp_q.push_back({1'b0, col[7:0]});
    end
  endtask

  function automatic int first_diff();
    int m;
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return m;
    return -1;
  endfunction

  task automatic clear_obs();
    got_q.delete();
    acc_cnt = 0; done_cnt = 0; err_cnt = 0;
    first_valid_cyc = -1; valid_cnt = 0; busy_low_cnt = 0;
    last_xfer_cyc = -1; done_cyc = -1; err_cyc = -1; acc_cyc = -1;
  endtask

  // Issue one request and check stream, pulses, latency and busy.
  task automatic run_req(input logic [15:0] x0, x1, y0, y1, col,
                         input int pct, input string tag);
    bit ok;
    int n;
    ok = (x0 <= x1) && (y0 <= y1) && (x1 < 16'd240) && (y1 < 16'd320);
    exp_q.delete();
    if (ok) build_exp(x0, x1, y0, y1, col);
    clear_obs();
    ready_pct = pct;
    req_x0 = x0; req_x1 = x1; req_y0 = y0; req_y1 = y1; req_color = col;
    req_valid = 1'b1;
    n = 0;
    while (acc_cnt == 0 && n < 20) begin tick(); n++; end
    check({tag, "/accept"}, 32'(acc_cnt), 32'd1);
    req_valid = 1'b0;
    req_x0 = 16'($urandom); req_x1 = 16'($urandom);
    req_y0 = 16'($urandom); req_y1 = 16'($urandom);
    req_color = 16'($urandom);
    track_busy = 1'b1;
    n = 0;
    while (done_cnt == 0 && err_cnt == 0 && n < 8000) begin tick(); n++; end
    track_busy = 1'b0;
    check({tag, "/done_cnt"}, 32'(done_cnt), ok ? 32'd1 : 32'd0);
    check({tag, "/err_cnt"},  32'(err_cnt),  ok ? 32'd0 : 32'd1);
    check({tag, "/busy"},     32'(busy_low_cnt), 32'd0);
    check({tag, "/ready_after"}, 32'(req_ready), 32'd1);
    check({tag, "/pulse_len"}, 32'({done, err}), 32'd0);
    if (ok) begin
      check({tag, "/len"},        32'(got_q.size()), 32'(exp_q.size()));
      check({tag, "/stream_idx"}, 32'(first_diff()), 32'hFFFF_FFFF);
      check({tag, "/first_lat"},  32'(first_valid_cyc - acc_cyc), 32'd2);
      check({tag, "/done_lat"},   32'(done_cyc - last_xfer_cyc), 32'd1);
    end else begin
      check({tag, "/err_lat"},    32'(err_cyc - acc_cyc), 32'd2);
      check({tag, "/no_valid"},   32'(valid_cnt), 32'd0);
    end
  endtask

  initial begin
    logic [15:0] rx0, rx1, ry0, ry1, rc;
    int n, a1, d1;

    rst_n = 1'b0; req_valid = 1'b0; item_ready = 1'b1;
    req_x0 = '0; req_x1 = '0; req_y0 = '0; req_y1 = '0; req_color = '0;
    tick();
    tick();
    check("rst/item_valid", 32'(item_valid),  32'd0);
    check("rst/item_is_cmd",32'(item_is_cmd), 32'd0);
    check("rst/item_byte",  32'(item_byte),   32'h00);
    check("rst/busy",       32'(busy),        32'd0);
    check("rst/done",       32'(done),        32'd0);
    check("rst/err",        32'(err),         32'd0);
    check("rst/req_ready",  32'(req_ready),   32'd1);
    rst_n = 1'b1;
    tick();

    run_req(16'd10, 16'd10, 16'd20, 16'd20, 16'hF800, 100, "single");
    run_req(16'd10, 16'd10, 16'd20, 16'd20, 16'hF800, 30,  "backpress");
    run_req(16'd230, 16'd239, 16'd310, 16'd319, 16'h1234, 100, "corner");
    run_req(16'd200, 16'd239, 16'd318, 16'd319, 16'h1234, 40,  "corner_bp");
    run_req(16'd0, 16'd240, 16'd0, 16'd0, 16'h0000, 100, "x1_oob");
    run_req(16'd5, 16'd4, 16'd0, 16'd0, 16'hFFFF, 100, "x0_gt_x1");
    run_req(16'd0, 16'd0, 16'd0, 16'd320, 16'h0F0F, 100, "y1_oob");

    // Reset while streaming pixels.
    exp_q.delete();
    clear_obs();
    ready_pct = 100;
    req_x0 = 16'd0; req_x1 = 16'd9; req_y0 = 16'd0; req_y1 = 16'd9; req_color = 16'hBEEF;
    req_valid = 1'b1;
    n = 0;
    while (acc_cnt == 0 && n < 20) begin tick(); n++; end
    req_valid = 1'b0;
    n = 0;
    while (got_q.size() < 111 && n < 1000) begin tick(); n++; end
    check("midrst/progress", 32'(got_q.size()), 32'd111);
    done_cnt = 0; err_cnt = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst/item_valid", 32'(item_valid), 32'd0);
    check("midrst/req_ready",  32'(req_ready),  32'd1);
    check("midrst/busy",       32'(busy),       32'd0);
    repeat (5) tick();
    check("midrst/no_done", 32'(done_cnt + err_cnt), 32'd0);

    run_req(16'd1, 16'd2, 16'd3, 16'd4, 16'hA5C3, 50, "post_rst");
    check("post_rst/19items", 32'(got_q.size()), 32'd19);

    // Back-to-back with req_valid held high.
    exp_q.delete();
    build_exp(16'd5, 16'd6, 16'd7, 16'd7, 16'h55AA);
    build_exp(16'd5, 16'd6, 16'd7, 16'd7, 16'h55AA);
    clear_obs();
    ready_pct = 100;
    req_x0 = 16'd5; req_x1 = 16'd6; req_y0 = 16'd7; req_y1 = 16'd7; req_color = 16'h55AA;
    req_valid = 1'b1;
    n = 0;
    while (acc_cnt < 1 && n < 20) begin tick(); n++; end
    a1 = acc_cyc;
    n = 0;
    while (done_cnt < 1 && n < 200) begin tick(); n++; end
    d1 = done_cyc;
    n = 0;
    while (acc_cnt < 2 && n < 20) begin tick(); n++; end
    check("b2b/second_acc", 32'(acc_cyc - d1), 32'd1);
    check("b2b/first_acc_before_done", 32'(d1 > a1), 32'd1);
    req_valid = 1'b0;
    n = 0;
    while (done_cnt < 2 && n < 200) begin tick(); n++; end
    check("b2b/done_cnt",   32'(done_cnt), 32'd2);
    check("b2b/stream_idx", 32'(first_diff()), 32'hFFFF_FFFF);

    // Random rectangles, some deliberately invalid.
    for (int k = 0; k < 12; k++) begin
      rx0 = 16'($urandom_range(0, 236));
      rx1 = 16'(rx0 + 16'($urandom_range(0, 3)));
      ry0 = 16'($urandom_range(0, 316));
      ry1 = 16'(ry0 + 16'($urandom_range(0, 3)));
      rc  = 16'($urandom);
      if (k % 4 == 3) begin
        if (rx0 == 16'd0) rx0 = 16'd1;
        rx1 = 16'(rx0 - 16'd1);
      end
      run_req(rx0, rx1, ry0, ry1, rc, int'($urandom_range(25, 100)), $sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_fill_sequencer.md
Name: lcd_fill_sequencer

Overview:
Upstream stage of the ILI934x 8080 byte writer. It takes one fill-rectangle request (window corners plus an RGB565 colour) and expands it into an item stream for the writer's item_valid/item_ready port:
- CASET command and parameters
- PASET command and parameters
- RAMWR command
- 2 bytes per pixel

It runs one request at a time and reports done or err per request.

Parameters:
H_RES, 240, panel width in pixels; x1 must be < H_RES
V_RES, 320, panel height in pixels; y1 must be < V_RES

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  fill request present
req_ready  out  1  high only in IDLE
req_x0  in  16  window start column
req_x1  in  16  window end column, inclusive
req_y0  in  16  window start page
req_y1  in  16  window end page, inclusive
req_color  in  16  RGB565 fill colour
item_valid  out  1  stream byte valid, to the writer
item_is_cmd  out  1  1 = command byte (writer drives DC low)
item_byte  out  8  stream byte
item_ready  in  1  writer can accept
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the last pixel byte is accepted
err  out  1  one-cycle pulse on a rejected request

Behaviour:
- Clocking and reset:
  - One clock domain is clk.
  - Reset is synchronous and active-low on rst_n.
  - While rst_n is low at a clk edge: state = IDLE; item_valid, item_is_cmd, busy, done and err = 0; item_byte = 8'h00.
  - req_ready = 1 after reset (state is IDLE).
- Request handshake:
  - A request is accepted on a clk edge where req_valid && req_ready.
  - All req_* fields are latched on acceptance; later input changes are ignored until return to IDLE.
- Item handshake:
  - A transfer occurs on a clk edge where item_valid && item_ready.
  - While item_valid=1 and item_ready=0, item_byte and item_is_cmd hold stable. item_valid never drops without a transfer, except on reset.
  - item_byte and item_is_cmd are registered.
- States: IDLE -> CALC -> HDR -> PIX -> DONE -> IDLE. A rejected request goes CALC -> IDLE.
- IDLE: waits for req_valid.
- CALC: one cycle.
  - Checks that x0 <= x1, y0 <= y1, x1 < H_RES and y1 < V_RES.
  - Fail: err=1 for exactly one cycle, no item is ever emitted, next state IDLE.
  - Pass: pix_left = (x1-x0+1)*(y1-y0+1), computed in a 17-bit unsigned counter (max 76800). Loads the first header item and asserts item_valid.
  - Latency: the first item_valid appears 2 cycles after the acceptance edge.
- HDR: 11 items, index 0..10, advancing on each transfer.
  - Item order: 2A(cmd), x0[15:8], x0[7:0], x1[15:8], x1[7:0], 2B(cmd), y0[15:8], y0[7:0], y1[15:8], y1[7:0], 2C(cmd).
  - item_is_cmd = 1 only at indices 0, 5 and 10.
- PIX: alternates color[15:8] then color[7:0], with item_is_cmd = 0.
  - pix_left decrements on each low-byte transfer.
  - When the last low byte transfers (pix_left == 1), item_valid drops on that same edge and the state goes to DONE.
- DONE: done=1 for one cycle, then IDLE.
  - req_ready returns the following cycle.
  - Minimum of 1 cycle from done to the next acceptance.
- Total items per request = 11 + 2*pix_left. No item is ever emitted without a transfer.
- Reset mid-operation:
  - Aborts the request; outputs take their reset values at that edge.
  - No done or err pulse is produced.
  - A partially sent stream is the caller's responsibility; the writer is reset by the same rst_n.
- Simultaneous events: none possible. req_ready is 0 outside IDLE, and done/err are mutually exclusive.

Decomposition:
- ili934x_pkg gets the constants CMD_CASET = 8'h2A, CMD_PASET = 8'h2B, CMD_RAMWR = 8'h2C, and HDR_LEN = 11.
- The state enum fill_state_e (IDLE, CALC, HDR, PIX, DONE) stays local to the module.
- No sub-module. The header byte selection is a local function of the index and the latched fields.

Test Plan:
- Single pixel, req (10,20)-(10,20), colour F800, item_ready tied to 1:
  - Stream is 2A 00 0A 00 0A 2B 00 14 00 14 2C F8 00.
  - is_cmd is set only on 2A/2B/2C.
  - done pulses once, one cycle after the 00 transfer.
- Backpressure, same request with item_ready random at 30% high:
  - Identical stream.
  - item_byte and item_is_cmd are stable during every valid && !ready cycle.
  - No dropped or duplicated bytes.
- Full screen, (0,0)-(239,319), colour 1234, driving lcd8080_writer:
  - 153611 transfers: 76800 pairs of 12 34 after the header (x1 bytes 00 EF, y1 bytes 01 3F).
  - busy is high from acceptance until IDLE.
- Invalid request, x1 = 240 (and separately x0 = 5, x1 = 4):
  - err pulses exactly 1 cycle, 2 cycles after acceptance.
  - item_valid never rises; req_ready is high on the cycle after err.
- Reset during PIX after 100 pixel bytes:
  - item_valid = 0 and req_ready = 1 the cycle after the reset edge; no done.
  - A following 2x2 request emits a correct 19-item stream.
- Back-to-back requests with req_valid held high:
  - The second acceptance occurs exactly 1 cycle after the first done.
